irl_bucket_mem: RTL and testbench

IRL_BUCKET_MEM -- requirements
Module: irl_bucket_mem

---
 rtl/irl_mem_pkg.sv | 19 +
 rtl/irl_bucket_mem_if.sv | 43 ++++
 rtl/irl_wr_stage.sv | 53 +++++
 rtl/ram_1r1w.sv | 36 +++
 rtl/irl_bucket_mem.sv | 132 +++++++++++++
 tb/tb_irl_bucket_mem.sv | 265 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/irl_mem_pkg.sv
// Shared defaults and types for the bucket memory block.
// Defines the default geometry, the stall counter width and the read-port owner tag.
package irl_mem_pkg;

  localparam int IRL_WIDTH       = 36;
  localparam int IRL_DEPTH_NBITS = 12;
  localparam int IRL_NUM_SRC     = 2;
  localparam int STALL_CNT_W     = 16;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Which requester owns the data coming out of the RAM read register this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_APP  = 2'd1,
    RD_PIO  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/irl_bucket_mem_if.sv
// Bus bundle for irl_bucket_mem: source write ports, app read port, PIO port and status.
// The master modport is the requester side; the slave modport is the memory block.
interface irl_bucket_mem_if
  import irl_mem_pkg::*;
#(
  parameter int WIDTH       = IRL_WIDTH,
  parameter int DEPTH_NBITS = IRL_DEPTH_NBITS,
  parameter int NUM_SRC     = IRL_NUM_SRC
);

  logic [NUM_SRC-1:0]             src_wr;
  logic [NUM_SRC*DEPTH_NBITS-1:0] src_waddr;
  logic [NUM_SRC*WIDTH-1:0]       src_wdata;
  logic [NUM_SRC-1:0]             src_ready;

  logic                           rd;
  logic [DEPTH_NBITS-1:0]         raddr;
  logic                           ack;
  logic [WIDTH-1:0]               rdata;

  logic                           pio_req;
  logic                           pio_wr;
  logic [DEPTH_NBITS-1:0]         pio_addr;
  logic [WIDTH-1:0]               pio_wdata;
  logic                           pio_ack;
  logic [WIDTH-1:0]               pio_rdata;

  stall_cnt_t                     stall_cnt;
  logic                           par_err;

  modport master (
    output src_wr, src_waddr, src_wdata, rd, raddr,
           pio_req, pio_wr, pio_addr, pio_wdata,
    input  src_ready, ack, rdata, pio_ack, pio_rdata, stall_cnt, par_err
  );

  modport slave (
    input  src_wr, src_waddr, src_wdata, rd, raddr,
           pio_req, pio_wr, pio_addr, pio_wdata,
    output src_ready, ack, rdata, pio_ack, pio_rdata, stall_cnt, par_err
  );

endinterface

// File: rtl/irl_wr_stage.sv
// One-entry write stage for a single application source.
// Holds one write until the arbiter grants it; may reload in the same cycle it drains.
module irl_wr_stage
  import irl_mem_pkg::*;
#(
  parameter int WIDTH       = IRL_WIDTH,
  parameter int DEPTH_NBITS = IRL_DEPTH_NBITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_i,
  input  logic [DEPTH_NBITS-1:0] addr_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   grant_i,
  output logic                   vld_o,
  output logic [DEPTH_NBITS-1:0] addr_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   ready_o
);

  logic                   vld_q, vld_d;
  logic                   accept;
  logic [DEPTH_NBITS-1:0] addr_q;
  logic [WIDTH-1:0]       data_q;

  assign ready_o = ~vld_q | grant_i;
  assign accept  = wr_i & ready_o;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    vld_d = vld_q;
    if (accept)       vld_d = 1'b1;
    else if (grant_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  // Payload is only meaningful while vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/ram_1r1w.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// A read that hits the address being written in the same cycle returns the new data.
module ram_1r1w #(
  parameter int WIDTH       = 36,
  parameter int DEPTH_NBITS = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [DEPTH_NBITS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re,
  input  logic [DEPTH_NBITS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_NBITS];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto a RAM macro; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/irl_bucket_mem.sv
// Bucket memory: NUM_SRC staged write sources plus a PIO port share one RAM write port,
// app reads and PIO reads share the read port. Optional parity: IRL_BUCKET_MEM_PARITY_EN.
module irl_bucket_mem
  import irl_mem_pkg::*;
#(
  parameter int WIDTH       = IRL_WIDTH,
  parameter int DEPTH_NBITS = IRL_DEPTH_NBITS,
  parameter int NUM_SRC     = IRL_NUM_SRC
) (
  input  logic            clk,
  input  logic            rst_n,
  irl_bucket_mem_if.slave bus
);

`ifdef IRL_BUCKET_MEM_PARITY_EN
  localparam int RAM_W = WIDTH + 1;
`else
  localparam int RAM_W = WIDTH;
`endif

  logic [NUM_SRC-1:0]     stage_vld, stage_ready, grant;
  logic [DEPTH_NBITS-1:0] stage_addr [NUM_SRC];
  logic [WIDTH-1:0]       stage_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stage
    irl_wr_stage #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (bus.src_wr[i]),
      .addr_i  (bus.src_waddr[i*DEPTH_NBITS +: DEPTH_NBITS]),
      .data_i  (bus.src_wdata[i*WIDTH +: WIDTH]),
      .grant_i (grant[i]),
      .vld_o   (stage_vld[i]),
      .addr_o  (stage_addr[i]),
      .data_o  (stage_data[i]),
      .ready_o (stage_ready[i])
    );
  end

  assign bus.src_ready = stage_ready;

  logic                   pio_busy_q, pio_wr_q, pio_wack_q;
  logic [DEPTH_NBITS-1:0] pio_addr_q;
  logic [WIDTH-1:0]       pio_wdata_q, pio_rdata_q;
  rd_owner_e              rd_owner_q;
  stall_cnt_t             stall_cnt_q;

  logic                   any_vld, pio_wgrant, pio_rd_issue, pio_served, stall;
  logic                   ram_we, ram_re;
  logic [DEPTH_NBITS-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]       wdata_raw;
  logic [RAM_W-1:0]       ram_wdata, ram_rdata;

  // Walk from the top index down so the lowest-index valid stage wins the write port.
  always_comb begin
    grant     = '0;
    ram_waddr = pio_addr_q;
    wdata_raw = pio_wdata_q;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (stage_vld[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        ram_waddr = stage_addr[i];
        wdata_raw = stage_data[i];
      end
    end
  end

  assign any_vld      = |stage_vld;
  assign pio_wgrant   = pio_busy_q & pio_wr_q & ~any_vld;
  assign pio_rd_issue = pio_busy_q & ~pio_wr_q & ~bus.rd;
  assign pio_served   = pio_wgrant | pio_rd_issue;
  assign stall        = (|(stage_vld & ~grant)) | (pio_busy_q & ~pio_served);

  assign ram_we    = any_vld | pio_wgrant;
  assign ram_re    = bus.rd | pio_rd_issue;
  assign ram_raddr = bus.rd ? bus.raddr : pio_addr_q;

  ram_1r1w #(.WIDTH(RAM_W), .DEPTH_NBITS(DEPTH_NBITS)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pio_busy_q  <= 1'b0;
      pio_wr_q    <= 1'b0;
      pio_addr_q  <= '0;
      pio_wdata_q <= '0;
      pio_wack_q  <= 1'b0;
      pio_rdata_q <= '0;
      rd_owner_q  <= RD_NONE;
      stall_cnt_q <= '0;
    end else begin
      pio_wack_q <= pio_wgrant;
      rd_owner_q <= bus.rd ? RD_APP : (pio_rd_issue ? RD_PIO : RD_NONE);
      if (rd_owner_q == RD_PIO) pio_rdata_q <= ram_rdata[WIDTH-1:0];
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + stall_cnt_t'(1);
      // A request arriving while an access is outstanding is dropped, not queued.
      if (pio_served) begin
        pio_busy_q <= 1'b0;
      end else if (!pio_busy_q && bus.pio_req) begin
        pio_busy_q  <= 1'b1;
        pio_wr_q    <= bus.pio_wr;
        pio_addr_q  <= bus.pio_addr;
        pio_wdata_q <= bus.pio_wdata;
      end
    end
  end

  assign bus.ack       = (rd_owner_q == RD_APP);
  assign bus.rdata     = ram_rdata[WIDTH-1:0];
  assign bus.pio_ack   = pio_wack_q | (rd_owner_q == RD_PIO);
  assign bus.pio_rdata = (rd_owner_q == RD_PIO) ? ram_rdata[WIDTH-1:0] : pio_rdata_q;
  assign bus.stall_cnt = stall_cnt_q;

`ifdef IRL_BUCKET_MEM_PARITY_EN
  // Even parity: the stored word XORs to zero when intact.
  assign ram_wdata   = {^wdata_raw, wdata_raw};
  assign bus.par_err = (rd_owner_q != RD_NONE) & (^ram_rdata);
`else
  assign ram_wdata   = wdata_raw;
  assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_irl_bucket_mem.sv
// Directed bench for irl_bucket_mem: table-driven write/readback plus hand-written
// sequences for arbitration, write-first, PIO hold-off, stall saturation and reset.
module tb_irl_bucket_mem;

  localparam int W  = 36;
  localparam int AW = 12;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irl_bucket_mem_if #(.WIDTH(W), .DEPTH_NBITS(AW), .NUM_SRC(NS)) bus ();

  irl_bucket_mem #(.WIDTH(W), .DEPTH_NBITS(AW), .NUM_SRC(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          pio;
    int            src;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } vec_t;

  vec_t vecs[7];

  logic         r_ok;
  logic [W-1:0] r_data;
  logic         r_pe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.src_wr    = '0;
    bus.src_waddr = '0;
    bus.src_wdata = '0;
    bus.rd        = 1'b0;
    bus.raddr     = '0;
    bus.pio_req   = 1'b0;
    bus.pio_wr    = 1'b0;
    bus.pio_addr  = '0;
    bus.pio_wdata = '0;
  endtask

  task automatic app_write(input int src, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.src_wr[src]              = 1'b1;
    bus.src_waddr[src*AW +: AW]  = a;
    bus.src_wdata[src*W +: W]    = d;
    tick();
    bus.src_wr = '0;
  endtask

  task automatic app_read(input logic [AW-1:0] a, output logic ackv,
                          output logic [W-1:0] dv, output logic pe);
    bus.rd    = 1'b1;
    bus.raddr = a;
    tick();
    bus.rd = 1'b0;
    ackv   = bus.ack;
    dv     = bus.rdata;
    pe     = bus.par_err;
  endtask

  // Issues one PIO access and waits a bounded number of cycles for pio_ack.
  task automatic pio_op(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                        output logic ok, output logic [W-1:0] dv, output logic pe);
    bus.pio_req   = 1'b1;
    bus.pio_wr    = wr;
    bus.pio_addr  = a;
    bus.pio_wdata = d;
    tick();
    bus.pio_req = 1'b0;
    ok = 1'b0;
    dv = '0;
    pe = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (bus.pio_ack) begin
        ok = 1'b1;
        dv = bus.pio_rdata;
        pe = bus.par_err;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 0, 12'h000, 36'h0_0000_0001};
    vecs[1] = '{1'b0, 1, 12'hFFF, 36'hF_FFFF_FFFF};
    vecs[2] = '{1'b1, 0, 12'h003, 36'h9_8765_4321};
    vecs[3] = '{1'b0, 0, 12'h009, 36'h0_0000_00AB};
    vecs[4] = '{1'b1, 0, 12'h015, 36'h0_0000_0111};
    vecs[5] = '{1'b0, 1, 12'h800, 36'h0_0000_0000};
    vecs[6] = '{1'b1, 0, 12'h002, 36'h0_0000_0055};

    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check("rst_src_ready", bus.src_ready, 2'b11);
    check("rst_ack", bus.ack, 1'b0);
    check("rst_pio_ack", bus.pio_ack, 1'b0);
    check("rst_par_err", bus.par_err, 1'b0);
    check("rst_stall_cnt", bus.stall_cnt, 16'h0000);
    check("rst_rdata", bus.rdata, 36'h0);
    check("rst_pio_rdata", bus.pio_rdata, 36'h0);

    // Table: write every vector, then read every vector back through the same kind of port.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pio) begin
        pio_op(1'b1, vecs[i].addr, vecs[i].data, r_ok, r_data, r_pe);
        check($sformatf("vec%0d_pio_wr_ack", i), r_ok, 1'b1);
        tick();
      end else begin
        app_write(vecs[i].src, vecs[i].addr, vecs[i].data);
        tick();
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pio) begin
        pio_op(1'b0, vecs[i].addr, '0, r_ok, r_data, r_pe);
        tick();
      end else begin
        app_read(vecs[i].addr, r_ok, r_data, r_pe);
      end
      check($sformatf("vec%0d_ack", i), r_ok, 1'b1);
      check($sformatf("vec%0d_data", i), r_data, vecs[i].data);
      check($sformatf("vec%0d_par_err", i), r_pe, 1'b0);
    end
    check("table_no_stall", bus.stall_cnt, 16'h0000);

    // Two sources write together: src0 (addr 5) first, src1 (addr 9) one cycle later.
    bus.src_wr    = 2'b11;
    bus.src_waddr = {12'd9, 12'd5};
    bus.src_wdata = {36'h9_0000_0009, 36'h5_0000_0005};
    check("arb_ready_pre", bus.src_ready, 2'b11);
    tick();
    bus.src_wr = '0;
    check("arb_ready_src1_blocked", bus.src_ready, 2'b01);
    bus.rd    = 1'b1;
    bus.raddr = 12'd9;
    tick();
    check("arb_ack", bus.ack, 1'b1);
    check("arb_addr9_not_yet", bus.rdata, 36'h0_0000_00AB);
    check("arb_ready_free", bus.src_ready, 2'b11);
    check("arb_stall_one", bus.stall_cnt, 16'd1);
    bus.raddr = 12'd9;
    tick();
    check("arb_addr9_written", bus.rdata, 36'h9_0000_0009);
    bus.raddr = 12'd5;
    tick();
    bus.rd = 1'b0;
    check("arb_addr5_written", bus.rdata, 36'h5_0000_0005);
    check("arb_stall_still_one", bus.stall_cnt, 16'd1);

    // Read of addr 7 in the same cycle the staged write to addr 7 is granted.
    app_write(0, 12'd7, 36'h0_0000_0123);
    check("wf_ack_idle", bus.ack, 1'b0);
    app_read(12'd7, r_ok, r_data, r_pe);
    check("wf_ack", r_ok, 1'b1);
    check("wf_rdata", r_data, 36'h0_0000_0123);

    // PIO read of addr 3 held off while rd stays high for four cycles.
    bus.pio_req  = 1'b1;
    bus.pio_wr   = 1'b0;
    bus.pio_addr = 12'd3;
    for (int k = 0; k < 4; k++) begin
      bus.rd    = 1'b1;
      bus.raddr = 12'd0;
      tick();
      bus.pio_req = 1'b0;
      check($sformatf("pio_held_%0d", k), bus.pio_ack, 1'b0);
    end
    bus.rd = 1'b0;
    tick();
    check("pio_ack_after_rd", bus.pio_ack, 1'b1);
    check("pio_rdata", bus.pio_rdata, 36'h9_8765_4321);
    tick();
    check("pio_ack_one_cycle", bus.pio_ack, 1'b0);
    check("pio_rdata_hold", bus.pio_rdata, 36'h9_8765_4321);

    // src0 writes every cycle for 70000 cycles while src1 sits pending.
    bus.src_wr    = 2'b11;
    bus.src_waddr = {12'd100, 12'h7F0};
    bus.src_wdata = {36'h0_0000_05A5, 36'h0};
    tick();
    bus.src_wr = 2'b01;
    for (int i = 1; i < 70000; i++) begin
      bus.src_wdata[W-1:0] = W'(i);
      tick();
    end
    bus.src_wr = '0;
    check("sat_src1_pending", bus.src_ready, 2'b01);
    check("sat_stall_max", bus.stall_cnt, 16'hFFFF);
    tick();
    tick();
    check("sat_stall_hold", bus.stall_cnt, 16'hFFFF);
    check("sat_ready_idle", bus.src_ready, 2'b11);
    app_read(12'd100, r_ok, r_data, r_pe);
    check("sat_src1_not_lost", r_data, 36'h0_0000_05A5);
    app_read(12'h7F0, r_ok, r_data, r_pe);
    check("sat_src0_last", r_data, 36'd69999);

    // Reset while stage 1 holds a write: the write must vanish.
    bus.src_wr    = 2'b11;
    bus.src_waddr = {12'h015, 12'h014};
    bus.src_wdata = {36'h0_0000_0BAD, 36'h0_0000_0020};
    tick();
    bus.src_wr = '0;
    check("mrst_stage1_valid", bus.src_ready, 2'b01);
    #2 rst_n = 1'b0;
    #2;
    check("mrst_ready_in_reset", bus.src_ready, 2'b11);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("mrst_ready_after", bus.src_ready, 2'b11);
    check("mrst_stall_clear", bus.stall_cnt, 16'h0000);
    check("mrst_pio_rdata_clear", bus.pio_rdata, 36'h0);
    check("mrst_ack_clear", bus.ack, 1'b0);
    tick();
    tick();
    app_read(12'h015, r_ok, r_data, r_pe);
    check("mrst_staged_dropped", r_data, 36'h0_0000_0111);

`ifdef IRL_BUCKET_MEM_PARITY_EN
    // Flip the stored parity bit of addr 2 and expect par_err with the ack.
    dut.u_ram.mem_q[2][W] = ~dut.u_ram.mem_q[2][W];
    app_read(12'd2, r_ok, r_data, r_pe);
    check("par_ack", r_ok, 1'b1);
    check("par_err_flag", r_pe, 1'b1);
    app_read(12'd3, r_ok, r_data, r_pe);
    check("par_clean_word", r_pe, 1'b0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
